// File: rtl/cond_logic.sv
// Conditional-execution stage: holds NZCV, evaluates the condition field and gates decoder write strobes.
// Optional feature macro: COND_LOGIC_CARRY_BYPASS_EN adds the carry_in output (registered C flag).
module cond_logic (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [1:0] flag_w,
    input  logic       pcs,
    input  logic       reg_w,
    input  logic       mem_w,
    input  logic       no_write,
    output logic       pc_src,
    output logic       reg_write,
    output logic       mem_write,
    output logic       cond_ex,
    output logic [3:0] flags
`ifdef COND_LOGIC_CARRY_BYPASS_EN
    ,
    output logic       carry_in
`endif
);

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } condCode_t;

    logic [3:0] r_flags;
    logic       w_n;
    logic       w_z;
    logic       w_c;
    logic       w_v;
    logic       w_condPass;
    logic       w_active;

    assign w_n = r_flags[3];
    assign w_z = r_flags[2];
    assign w_c = r_flags[1];
    assign w_v = r_flags[0];

    // Evaluated only against the registered flags, so an instruction never sees its own flag writes.
    always_comb begin
        w_condPass = 1'b0;
        case (condCode_t'(cond))
            COND_EQ: w_condPass = w_z;
            COND_NE: w_condPass = ~w_z;
            COND_CS: w_condPass = w_c;
            COND_CC: w_condPass = ~w_c;
            COND_MI: w_condPass = w_n;
            COND_PL: w_condPass = ~w_n;
            COND_VS: w_condPass = w_v;
            COND_VC: w_condPass = ~w_v;
            COND_HI: w_condPass = w_c & ~w_z;
            COND_LS: w_condPass = ~w_c | w_z;
            COND_GE: w_condPass = ~(w_n ^ w_v);
            COND_LT: w_condPass = w_n ^ w_v;
            COND_GT: w_condPass = ~w_z & ~(w_n ^ w_v);
            COND_LE: w_condPass = w_z | (w_n ^ w_v);
            COND_AL: w_condPass = 1'b1;
            COND_NV: w_condPass = 1'b0;
            default: w_condPass = 1'b0;
        endcase
    end

    assign w_active  = en & w_condPass;
    assign cond_ex   = w_condPass;
    assign pc_src    = w_active & pcs;
    assign reg_write = w_active & reg_w & ~no_write;
    assign mem_write = w_active & mem_w;
    assign flags     = r_flags;

    // N,Z and C,V halves commit independently under the decoder's mask.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flags <= 4'b0000;
        end else if (w_active) begin
            if (flag_w[1]) r_flags[3:2] <= alu_flags[3:2];
            if (flag_w[0]) r_flags[1:0] <= alu_flags[1:0];
        end
    end

`ifdef COND_LOGIC_CARRY_BYPASS_EN
    assign carry_in = r_flags[1];
`endif

endmodule
